// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, state encoding and baud divisor helper for the SPART driver
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        ST_PROG_LO  = 3'd0,
        ST_PROG_HI  = 3'd1,
        ST_WAIT_RDA = 3'd2,
        ST_READ_RX  = 3'd3,
        ST_WAIT_TBR = 3'd4,
        ST_WRITE_TX = 3'd5
    } state_t;

    // Rounded divisor minus one, as loaded into the SPART baud generator.
    function automatic logic [15:0] baud_div(input logic [1:0] cfg, input longint clk_hz,
                                             input longint oversample);
        longint baud;
        longint den;
        longint q;
        case (cfg)
            2'b00:   baud = 4800;
            2'b01:   baud = 9600;
            2'b10:   baud = 19200;
            default: baud = 38400;
        endcase
        den = oversample * baud;
        q   = (clk_hz + den / 2) / den - 1;
        return q[15:0];
    endfunction

endpackage

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - programs the SPART baud divisor, then echoes every received byte
module spart_driver
    import spart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic [7:0]  last_char,
    output logic [15:0] char_count,
    output logic        tx_timeout
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [15:0] DB_0 = baud_div(2'd0, longint'(CLK_HZ), longint'(OVERSAMPLE));
    localparam logic [15:0] DB_1 = baud_div(2'd1, longint'(CLK_HZ), longint'(OVERSAMPLE));
    localparam logic [15:0] DB_2 = baud_div(2'd2, longint'(CLK_HZ), longint'(OVERSAMPLE));
    localparam logic [15:0] DB_3 = baud_div(2'd3, longint'(CLK_HZ), longint'(OVERSAMPLE));

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_br_cfg_q;
    logic [7:0]    r_rx_byte;
    logic [7:0]    r_last_char;
    logic [15:0]   r_char_count;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_tx_timeout;

    logic [1:0]    w_db_cfg;
    logic [15:0]   w_db;
    logic          w_tmo_hit;
    logic          w_acc;
    logic          w_rd;
    logic [1:0]    w_addr;
    logic [7:0]    w_wdata;

    // The low byte is written in the same cycle br_cfg is latched, so it uses the live input.
    assign w_db_cfg  = (r_state == ST_PROG_LO) ? br_cfg : r_br_cfg_q;
    assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_db = DB_3;
        case (w_db_cfg)
            2'b00:   w_db = DB_0;
            2'b01:   w_db = DB_1;
            2'b10:   w_db = DB_2;
            default: w_db = DB_3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PROG_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PROG_LO:  w_next = ST_PROG_HI;
            ST_PROG_HI:  w_next = ST_WAIT_RDA;
            ST_WAIT_RDA: begin
                if (br_cfg != r_br_cfg_q) begin
                    w_next = ST_PROG_LO;
                end else if (rda) begin
                    w_next = ST_READ_RX;
                end
            end
            ST_READ_RX:  w_next = ST_WAIT_TBR;
            ST_WAIT_TBR: begin
                if (tbr) begin
                    w_next = ST_WRITE_TX;
                end else if (w_tmo_hit) begin
                    w_next = ST_WAIT_RDA;
                end
            end
            ST_WRITE_TX: w_next = ST_WAIT_RDA;
            default:     w_next = ST_PROG_LO;
        endcase
    end

    always_comb begin
        w_acc   = 1'b0;
        w_rd    = 1'b1;
        w_addr  = ADDR_BUF;
        w_wdata = 8'h00;
        case (r_state)
            ST_PROG_LO: begin
                w_acc   = 1'b1;
                w_rd    = 1'b0;
                w_addr  = ADDR_DBL;
                w_wdata = w_db[7:0];
            end
            ST_PROG_HI: begin
                w_acc   = 1'b1;
                w_rd    = 1'b0;
                w_addr  = ADDR_DBH;
                w_wdata = w_db[15:8];
            end
            ST_READ_RX: begin
                w_acc   = 1'b1;
            end
            ST_WRITE_TX: begin
                w_acc   = 1'b1;
                w_rd    = 1'b0;
                w_wdata = r_rx_byte;
            end
            default: begin
                w_acc   = 1'b0;
            end
        endcase
    end

    // Reset gates the bus immediately, even when it lands in the middle of an access.
    assign iocs    = w_acc & ~rst;
    assign iorw    = w_rd | rst;
    assign ioaddr  = rst ? ADDR_BUF : w_addr;
    assign databus = (w_acc & ~w_rd & ~rst) ? w_wdata : 8'hzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cfg_q   <= br_cfg;
            r_rx_byte    <= 8'h00;
            r_last_char  <= 8'h00;
            r_char_count <= 16'h0000;
            r_tmo_cnt    <= '0;
            r_tx_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_PROG_LO: r_br_cfg_q <= br_cfg;
                ST_READ_RX: begin
                    r_rx_byte <= databus;
                    r_tmo_cnt <= '0;
                end
                ST_WAIT_TBR: begin
                    if (!tbr) begin
                        if (w_tmo_hit) begin
                            r_tx_timeout <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE_TX: begin
                    r_last_char  <= r_rx_byte;
                    r_char_count <= r_char_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign last_char  = r_last_char;
    assign char_count = r_char_count;
    assign tx_timeout = r_tx_timeout;

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - randomized echo traffic against a transaction-level SPART bus model
module tb_spart_driver;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  br_cfg = 2'b00;
    logic        rda = 1'b0;
    logic        tbr = 1'b0;
    wire         iocs;
    wire         iorw;
    wire  [1:0]  ioaddr;
    wire  [7:0]  databus;
    wire  [7:0]  last_char;
    wire  [15:0] char_count;
    wire         tx_timeout;
    logic [7:0]  rx_reg = 8'h00;

    spart_driver #(.CLK_HZ(50_000_000), .OVERSAMPLE(16), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .last_char(last_char), .char_count(char_count), .tx_timeout(tx_timeout)
    );

    // SPART side of the bus: RX buffer returned on reads
    assign databus = (iocs && iorw) ? rx_reg : 8'hzz;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [10:0] t;
    } ev_t;

    ev_t         log_q[$];
    logic [10:0] exp_q[$];

    always @(negedge clk) begin
        ev_t e;
        if (iocs) begin
            e.cyc = cyc;
            e.t   = {iorw, ioaddr, databus};
            log_q.push_back(e);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [1:0]  m_cfg_q;
    logic [7:0]  m_last;
    logic [15:0] m_count;
    logic        m_tmo;

    function automatic logic [15:0] ref_db(input logic [1:0] c);
        case (c)
            2'b00:   return 16'd650;
            2'b01:   return 16'd325;
            2'b10:   return 16'd162;
            default: return 16'd80;
        endcase
    endfunction

    function automatic logic [10:0] wr_ev(input logic [1:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    task automatic push_prog(input logic [1:0] c);
        logic [15:0] db;
        db = ref_db(c);
        exp_q.push_back(wr_ev(2'b10, db[7:0]));
        exp_q.push_back(wr_ev(2'b11, db[15:8]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input logic rw, input string tag, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iocs && iorw == rw && ioaddr == 2'b00) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({tag, " strobe seen"}, 32'd0, 32'd1);
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, " n_access"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s acc%0d", tag, i), {21'd0, log_q[i].t}, {21'd0, exp_q[i]});
        log_q.delete();
        exp_q.delete();
    endtask

    // One echo: the DUT is idle in WAIT_RDA on entry; d>=TMO means tbr never rises.
    task automatic do_echo(input logic [7:0] b, input int d, input bit chg, input logic [1:0] ncfg);
        int n, rc, tc, wc, lat;
        lat = 1;
        if (br_cfg != m_cfg_q) begin
            push_prog(br_cfg);
            m_cfg_q = br_cfg;
            lat = 4;
        end
        rx_reg = b;
        n = cyc;
        rda = 1'b1;
        wait_strobe(1'b1, "read", rc);
        if (rc >= 0) check("read latency", rc - n, lat);
        exp_q.push_back({1'b1, 2'b00, b});
        @(posedge clk);
        #1;
        rda = 1'b0;
        if (chg) br_cfg = ncfg;
        if (d >= TMO) begin
            repeat (TMO - 1) tick();
            check("tmo before expiry", {31'd0, tx_timeout}, {31'd0, m_tmo});
            tick();
            m_tmo = 1'b1;
            check("tmo set", {31'd0, tx_timeout}, 32'd1);
            check("count after tmo", {16'd0, char_count}, {16'd0, m_count});
        end else begin
            repeat (d) tick();
            tbr = 1'b1;
            tc = cyc;
            wait_strobe(1'b0, "write", wc);
            if (wc >= 0) check("write latency", wc - tc, 1);
            exp_q.push_back(wr_ev(2'b00, b));
            m_count = m_count + 16'd1;
            m_last = b;
            @(posedge clk);
            #1;
            tbr = 1'b0;
            check("last_char", {24'd0, last_char}, {24'd0, m_last});
            check("char_count", {16'd0, char_count}, {16'd0, m_count});
        end
    endtask

    task automatic release_and_check_prog(input string tag);
        int r;
        logic [15:0] db;
        db = ref_db(br_cfg);
        m_cfg_q = br_cfg;
        m_count = 16'd0;
        m_last  = 8'h00;
        m_tmo   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r = cyc;
        repeat (6) tick();
        if (log_q.size() >= 2) begin
            check({tag, " lo cycle"}, log_q[0].cyc - r, 0);
            check({tag, " hi cycle"}, log_q[1].cyc - r, 1);
        end
        exp_q.push_back(wr_ev(2'b10, db[7:0]));
        exp_q.push_back(wr_ev(2'b11, db[15:8]));
        compare_log(tag);
    endtask

    initial begin
        int wc;
        logic [7:0] b;
        int d;
        bit chg;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst iocs", {31'd0, iocs}, 32'd0);
        check("rst iorw", {31'd0, iorw}, 32'd1);
        check("rst ioaddr", {30'd0, ioaddr}, 32'd0);
        check("rst databus z", {31'd0, (databus === 8'hzz)}, 32'd1);
        check("rst last_char", {24'd0, last_char}, 32'd0);
        check("rst char_count", {16'd0, char_count}, 32'd0);
        check("rst tx_timeout", {31'd0, tx_timeout}, 32'd0);
        check("prog 4800 lo const", {24'd0, ref_db(2'b00) & 16'hff}, 32'h8A);

        release_and_check_prog("reset prog");

        do_echo(8'h41, 0, 1'b0, 2'b00);
        compare_log("echo 41");

        do_echo(8'($urandom), 5, 1'b0, 2'b00);
        compare_log("tbr delay 5");

        do_echo(8'($urandom), 2, 1'b1, 2'b11);
        do_echo(8'($urandom), 0, 1'b0, 2'b00);
        compare_log("cfg change");

        do_echo(8'($urandom), TMO, 1'b0, 2'b00);
        do_echo(8'($urandom), 1, 1'b0, 2'b00);
        compare_log("timeout");

        for (int k = 0; k < 30; k++) begin
            b   = 8'($urandom);
            d   = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, 4));
            chg = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) br_cfg = 2'($urandom);
            do_echo(b, d, chg, 2'($urandom));
        end
        compare_log("random");

        rx_reg = 8'h5A;
        rda = 1'b1;
        tbr = 1'b1;
        wait_strobe(1'b0, "write before rst", wc);
        rst = 1'b1;
        #1;
        check("midrst iocs", {31'd0, iocs}, 32'd0);
        check("midrst databus z", {31'd0, (databus === 8'hzz)}, 32'd1);
        check("midrst iorw", {31'd0, iorw}, 32'd1);
        rda = 1'b0;
        tbr = 1'b0;
        br_cfg = 2'b01;
        @(posedge clk);
        #1;
        check("midrst char_count", {16'd0, char_count}, 32'd0);
        check("midrst last_char", {24'd0, last_char}, 32'd0);
        check("midrst tx_timeout", {31'd0, tx_timeout}, 32'd0);
        log_q.delete();
        exp_q.delete();
        release_and_check_prog("post rst prog");

        do_echo(8'($urandom), 1, 1'b0, 2'b00);
        compare_log("post rst echo");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
